db15_joy_scanner: RTL and testbench
===================================

Name: db15_joy_scanner

Overview:
Serial front end for the DB15 UserIO joystick adapter: two chained 74HC165 pairs carry 16 active-low buttons per player. The block drives the load and shift clock, samples the serial data line, and filters each frame. It publishes two active-high 16-bit joystick words in the `----LS FEDCBAUDLR` layout. Its outputs feed the joystick mux ahead of `hps_io` `joy_raw` and the core inputs; its pins feed the USER_OUT/USER_IN mapping.

Parameters:
CLK_DIV, 24, clk cycles per tick (48 MHz / 24 = 2 MHz tick, 1 MHz shift clock)
LOAD_TICKS, 2, ticks JOY_LOAD is held low
GAP_TICKS, 32, idle ticks between frames
BITS, 32, total serial bits per frame (16 per player)

Ports:
clk  in  1  system clock, 40-50 MHz
reset  in  1  asynchronous, active-high
enable  in  1  scanner enable (UserIO mode = DB15)
JOY_DATA  in  1  serial data from 74HC165 QH, active-low buttons
JOY_CLK  out  1  shift clock to 74HC165
JOY_LOAD  out  1  parallel load, active-low
joystick1  out  16  player 1 buttons, active-high
joystick2  out  16  player 2 buttons, active-high
frame_stb  out  1  one-clk pulse when a frame completes

Behaviour:
- Reset values: JOY_CLK=0, JOY_LOAD=1, joystick1=0, joystick2=0, frame_stb=0. State=LOAD, div=0, bit=0, prev_valid=0.
- Tick generator: div counts 0..CLK_DIV-1 and wraps. tick=1 when div==CLK_DIV-1. The first tick after reset release is at clk CLK_DIV. div runs freely while enable=1.
- FSM (advances only on tick):
  - LOAD: JOY_LOAD=0, JOY_CLK=0 for LOAD_TICKS ticks, then JOY_LOAD=1, go to SHIFT_LO.
  - SHIFT_LO: sample JOY_DATA into sr bit (BITS-1-bit), MSB-first. Set JOY_CLK=1, go to SHIFT_HI.
  - SHIFT_HI: JOY_CLK=0, bit++. If bit was BITS-1, go to GAP and raise frame_stb for 1 clk; else go to SHIFT_LO.
  - GAP: lines idle (CLK=0, LOAD=1) for GAP_TICKS ticks, then go to LOAD.
  - Frame period = LOAD_TICKS + 2*BITS + GAP_TICKS ticks. Defaults: 98 ticks = 2352 clk.
- The first bit is sampled on the first SHIFT_LO tick after LOAD, with no clock edge before it (QH already presents bit H).
- Frame completion: raw = sr including the final sample. prev is updated to raw every frame.
- Filter: if prev_valid && raw==prev, then joystick1<=~raw[31:16] and joystick2<=~raw[15:0] in the same clk as frame_stb. Otherwise outputs hold. prev_valid<=1.
- Output update latency is therefore ≥2 identical frames after any change. A single-frame glitch never reaches the outputs.
- enable=0 is a synchronous abort, taking effect the next clk regardless of tick:
  - state=LOAD with counters cleared, div=0, JOY_CLK=0, JOY_LOAD=1;
  - joystick1/2=0, prev_valid=0, frame_stb=0.
  - Scanning restarts when enable returns to 1; the first tick follows CLK_DIV clks later.
- Reset mid-frame clears everything asynchronously; no partial frame is ever published.
- Simultaneous frame completion and enable falling: enable wins, no output update and no frame_stb.
- bit counter is 5-bit, wraps to 0 on entering GAP. Tick-count counters are sized for max(LOAD_TICKS, GAP_TICKS).
- JOY_CLK and JOY_LOAD are registered outputs, glitch-free.

Test Plan:
- Reset release, enable=1, JOY_DATA=1 constant -> first JOY_LOAD fall at clk 24, low for 48 clk. 32 JOY_CLK pulses each 24 clk high / 24 clk low. frame_stb every 2352 clk; joystick1/2 remain 0x0000.
- 165 model holding P1=0xFFFE (R pressed), P2=0x7FFF for 2 frames -> after the 2nd frame_stb, joystick1=0x0001 and joystick2=0x8000. After only the first frame_stb, both are still 0x0000.
- One-frame glitch: P1 bit 4 low in frame N only, surrounded by stable frames of all-high -> joystick1 never shows 0x0010.
- enable dropped mid-SHIFT (bit 10) -> next clk JOY_CLK=0, JOY_LOAD=1, outputs 0, no frame_stb. Re-enable -> LOAD begins 24 clk later; outputs valid only after 2 full frames.
- Async reset pulse between clk edges during GAP with outputs 0x00FF -> outputs 0 immediately, no clk required. Scan restarts at LOAD.
- Parameter override CLK_DIV=4, GAP_TICKS=0, LOAD_TICKS=1 -> frame period = 65 ticks = 260 clk, verified by frame_stb spacing.

Source files
------------

// File: rtl/db15_joy_scanner.sv
`timescale 1ns/1ps
// DB15 joystick front end: scans two chained 74HC165 pairs, debounces by
// requiring two identical consecutive frames, publishes active-high buttons.
module db15_joy_scanner #(
  parameter int CLK_DIV    = 24,
  parameter int LOAD_TICKS = 2,
  parameter int GAP_TICKS  = 32,
  parameter int BITS       = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        JOY_DATA,
  output logic        JOY_CLK,
  output logic        JOY_LOAD,
  output logic [15:0] joystick1,
  output logic [15:0] joystick2,
  output logic        frame_stb
);

  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int CNT_MAX = (LOAD_TICKS > GAP_TICKS) ? LOAD_TICKS : GAP_TICKS;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int BIT_W   = $clog2(BITS);

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] LOAD_LAST = CNT_W'(LOAD_TICKS - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(BITS - 1);

  typedef enum logic [1:0] {
    S_LOAD     = 2'd0,
    S_SHIFT_LO = 2'd1,
    S_SHIFT_HI = 2'd2,
    S_GAP      = 2'd3
  } state_t;

  state_t            state;
  logic [DIV_W-1:0]  div;
  logic [CNT_W-1:0]  cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic [BITS-1:0]   sr;
  logic [BITS-1:0]   prev;
  logic              prev_valid;
  logic              tick;

  assign tick = (div == DIV_LAST);

  // Tick divider, scan sequencer, frame capture and two-frame filter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_LOAD;
      div        <= {DIV_W{1'b0}};
      cnt        <= {CNT_W{1'b0}};
      bit_cnt    <= {BIT_W{1'b0}};
      sr         <= {BITS{1'b0}};
      prev       <= {BITS{1'b0}};
      prev_valid <= 1'b0;
      JOY_CLK    <= 1'b0;
      JOY_LOAD   <= 1'b1;
      joystick1  <= 16'h0000;
      joystick2  <= 16'h0000;
      frame_stb  <= 1'b0;
    end else if (!enable) begin
      state      <= S_LOAD;
      div        <= {DIV_W{1'b0}};
      cnt        <= {CNT_W{1'b0}};
      bit_cnt    <= {BIT_W{1'b0}};
      sr         <= {BITS{1'b0}};
      prev       <= {BITS{1'b0}};
      prev_valid <= 1'b0;
      JOY_CLK    <= 1'b0;
      JOY_LOAD   <= 1'b1;
      joystick1  <= 16'h0000;
      joystick2  <= 16'h0000;
      frame_stb  <= 1'b0;
    end else begin
      frame_stb <= 1'b0;
      div       <= tick ? {DIV_W{1'b0}} : div + 1'b1;
      if (tick) begin
        case (state)
          S_LOAD: begin
            // Out of reset/abort the load line is still high: first tick only drops it.
            if (JOY_LOAD) begin
              JOY_LOAD <= 1'b0;
              cnt      <= {CNT_W{1'b0}};
            end else if (cnt == LOAD_LAST) begin
              JOY_LOAD <= 1'b1;
              cnt      <= {CNT_W{1'b0}};
              state    <= S_SHIFT_LO;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          S_SHIFT_LO: begin
            sr      <= {sr[BITS-2:0], JOY_DATA};
            JOY_CLK <= 1'b1;
            state   <= S_SHIFT_HI;
          end
          S_SHIFT_HI: begin
            JOY_CLK <= 1'b0;
            if (bit_cnt == BIT_LAST) begin
              bit_cnt    <= {BIT_W{1'b0}};
              frame_stb  <= 1'b1;
              prev       <= sr;
              prev_valid <= 1'b1;
              if (prev_valid && (sr == prev)) begin
                joystick1 <= ~sr[31:16];
                joystick2 <= ~sr[15:0];
              end
              // With no gap the next load starts on this very tick.
              if (GAP_TICKS == 0) begin
                state    <= S_LOAD;
                JOY_LOAD <= 1'b0;
                cnt      <= {CNT_W{1'b0}};
              end else begin
                state <= S_GAP;
                cnt   <= {CNT_W{1'b0}};
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              state   <= S_SHIFT_LO;
            end
          end
          S_GAP: begin
            if (cnt == GAP_LAST) begin
              state    <= S_LOAD;
              JOY_LOAD <= 1'b0;
              cnt      <= {CNT_W{1'b0}};
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: begin
            state    <= S_LOAD;
            cnt      <= {CNT_W{1'b0}};
            bit_cnt  <= {BIT_W{1'b0}};
            JOY_CLK  <= 1'b0;
            JOY_LOAD <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_db15_joy_scanner.sv
`timescale 1ns/1ps
// Bench for db15_joy_scanner: 74HC165 pin model, frame-level reference model
// feeding a scoreboard, plus directed timing, abort and reset checks.
module tb_db15_joy_scanner;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b1;
  logic        joy_data;
  logic        joy_clk, joy_load, frame_stb;
  logic [15:0] joystick1, joystick2;

  logic        joy_clk2, joy_load2, frame_stb2;
  logic [15:0] joystick1b, joystick2b;

  logic [31:0] pins = 32'hFFFF_FFFF;
  logic [31:0] hc_sr;
  logic [31:0] exp_q[$];
  int          checks = 0;
  int          failures = 0;
  int          rst_events = 0;

  always #5 clk = ~clk;

  db15_joy_scanner dut (
    .clk(clk), .reset(reset), .enable(enable), .JOY_DATA(joy_data),
    .JOY_CLK(joy_clk), .JOY_LOAD(joy_load),
    .joystick1(joystick1), .joystick2(joystick2), .frame_stb(frame_stb)
  );

  db15_joy_scanner #(.CLK_DIV(4), .LOAD_TICKS(1), .GAP_TICKS(0), .BITS(32)) dut_fast (
    .clk(clk), .reset(reset), .enable(1'b1), .JOY_DATA(1'b1),
    .JOY_CLK(joy_clk2), .JOY_LOAD(joy_load2),
    .joystick1(joystick1b), .joystick2(joystick2b), .frame_stb(frame_stb2)
  );

  // Chained 74HC165 pair: parallel load while LOAD low, shift on CLK rise.
  always @(negedge joy_load or posedge joy_clk) begin
    if (!joy_load) hc_sr <= pins;
    else           hc_sr <= {hc_sr[30:0], 1'b1};
  end
  assign joy_data = hc_sr[31];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: a frame is the pin word latched at the end of load;
  // outputs take ~frame only when two consecutive frames agree.
  initial begin
    logic [31:0] m_prev;
    logic        m_valid;
    logic [15:0] m_j1, m_j2;
    logic        load_d;
    int          seen;
    m_prev = 32'h0; m_valid = 1'b0; m_j1 = 16'h0; m_j2 = 16'h0; load_d = 1'b1; seen = 0;
    forever begin
      @(posedge clk); #2;
      if (reset || !enable || rst_events != seen) begin
        seen    = rst_events;
        m_valid = 1'b0;
        m_j1    = 16'h0;
        m_j2    = 16'h0;
        exp_q.delete();
      end else if (joy_load && !load_d) begin
        if (m_valid && pins == m_prev) begin
          m_j1 = ~pins[31:16];
          m_j2 = ~pins[15:0];
        end
        m_prev  = pins;
        m_valid = 1'b1;
        exp_q.push_back({m_j1, m_j2});
      end
      load_d = joy_load;
    end
  end

  // Scoreboard monitor: every frame_stb must match the oldest expected frame.
  initial begin
    logic [31:0] e;
    forever begin
      @(posedge clk); #1;
      if (frame_stb && !reset) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_unexpected_stb got stb=1 required no pending frame");
        end else begin
          e = exp_q.pop_front();
          check("sb_joy", {joystick1, joystick2}, e);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_stb();
    int n = 0;
    do begin step(); n++; end while (!frame_stb && n < 3000);
    if (!frame_stb) begin
      checks++;
      failures++;
      $display("FAIL stb_timeout got no frame_stb required one within 3000 clk");
    end
  endtask

  task automatic count_until_load(input logic val, output int n);
    n = 0;
    do begin step(); n++; end while (joy_load != val && n < 3000);
  endtask

  initial begin
    int n, pulses, tot;
    logic pc;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_joy_clk", {31'd0, joy_clk}, 32'd0);
    check("rst_joy_load", {31'd0, joy_load}, 32'd1);
    check("rst_joy", {joystick1, joystick2}, 32'h0);
    check("rst_stb", {31'd0, frame_stb}, 32'd0);
    @(negedge clk) reset = 1'b0;

    // First frame timing with all buttons released
    count_until_load(1'b0, n);
    check("first_load_fall", n, 32'd24);
    count_until_load(1'b1, n);
    check("load_low_width", n, 32'd48);
    tot = 72; pulses = 0; pc = joy_clk; n = 0;
    do begin
      step(); n++; tot++;
      if (joy_clk && !pc) pulses++;
      pc = joy_clk;
    end while (!frame_stb && n < 3000);
    check("clk_pulses", pulses, 32'd32);
    check("first_stb_clk", tot, 32'd1608);
    n = 0;
    do begin step(); n++; end while (!frame_stb && n < 3000);
    check("stb_period", n, 32'd2352);

    // R pressed on P1, bit 15 pressed on P2: needs two matching frames
    pins = {16'hFFFE, 16'h7FFF};
    wait_stb();
    check("p_first_frame_hold", {joystick1, joystick2}, 32'h0);
    wait_stb();
    check("p_second_frame", {joystick1, joystick2}, {16'h0001, 16'h8000});

    // Abort mid-shift at bit 10
    count_until_load(1'b0, n);
    count_until_load(1'b1, n);
    pulses = 0; pc = joy_clk; n = 0;
    do begin
      step(); n++;
      if (joy_clk && !pc) pulses++;
      pc = joy_clk;
    end while (pulses < 10 && n < 3000);
    @(negedge clk) enable = 1'b0;
    step();
    check("abort_clk", {31'd0, joy_clk}, 32'd0);
    check("abort_load", {31'd0, joy_load}, 32'd1);
    check("abort_joy", {joystick1, joystick2}, 32'h0);
    pulses = frame_stb;
    repeat (100) begin step(); pulses += frame_stb; end
    check("abort_no_stb", pulses, 32'd0);
    @(negedge clk) enable = 1'b1;
    count_until_load(1'b0, n);
    check("reenable_load_fall", n, 32'd24);
    wait_stb();
    check("reenable_first_frame", {joystick1, joystick2}, 32'h0);
    wait_stb();
    check("reenable_second_frame", {joystick1, joystick2}, {16'h0001, 16'h8000});

    // Async reset during the gap with outputs 0x00FF
    pins = 32'hFF00_FF00;
    wait_stb();
    wait_stb();
    check("pre_reset_joy", {joystick1, joystick2}, 32'h00FF_00FF);
    repeat (5) step();
    #2 reset = 1'b1;
    rst_events++;
    #1;
    check("async_reset_joy", {joystick1, joystick2}, 32'h0);
    check("async_reset_load", {31'd0, joy_load}, 32'd1);
    reset = 1'b0;
    count_until_load(1'b0, n);
    check("post_reset_load_fall", n, 32'd24);
    wait_stb();
    check("post_reset_first", {joystick1, joystick2}, 32'h0);
    wait_stb();
    check("post_reset_second", {joystick1, joystick2}, 32'h00FF_00FF);

    // Single-frame glitch on P1 bit 4 must never be published
    pins = 32'hFFFF_FFFF;
    wait_stb();
    wait_stb();
    check("glitch_base", {16'h0, joystick1}, 32'h0);
    pins = 32'hFFEF_FFFF;
    wait_stb();
    check("glitch_frame", {16'h0, joystick1}, 32'h0);
    pins = 32'hFFFF_FFFF;
    wait_stb();
    check("glitch_after1", {16'h0, joystick1}, 32'h0);
    wait_stb();
    check("glitch_after2", {16'h0, joystick1}, 32'h0);

    // Randomized frames, each held for a random number of frames
    for (int f = 0; f < 12; f++) begin
      if ($urandom_range(0, 2) == 0) pins = $urandom;
      wait_stb();
    end

    // Fast instance: period 65 ticks of 4 clk
    n = 0;
    do begin step(); n++; end while (!frame_stb2 && n < 1000);
    n = 0;
    do begin step(); n++; end while (!frame_stb2 && n < 1000);
    check("fast_stb_period", n, 32'd260);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
